// File: rtl/jk_flip_flop_if.sv
// Bundle of the JK data signals (J, K, Q, Q_bar) for connecting a jk_flip_flop
// to the logic that drives it and the logic that reads it.
interface jk_flip_flop_if #(
    parameter int unsigned WIDTH = 1
) ();
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;

    modport master (
        output j,
        output k,
        input  q,
        input  q_bar
    );

    modport slave (
        input  j,
        input  k,
        output q,
        output q_bar
    );
endinterface

// File: rtl/jk_flip_flop.sv
// WIDTH independent JK flip-flops sharing one clock and a synchronous active-high reset.
// Define JKFF_SIM_CHECK_EN to compile in simulation-only X/Z and Q_bar consistency checks.
module jk_flip_flop #(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic             Reset,
    input  logic             Clk,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_bar
);

    // Per bit: set where J, keep where ~K; J&K together toggles the current value.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Q <= RESET_VALUE;
        end else begin
            Q <= (J & ~Q) | (~K & Q);
        end
    end

    // Complement is derived from the register so it can never disagree with Q.
    assign Q_bar = ~Q;

`ifdef JKFF_SIM_CHECK_EN
    logic reset_seen;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            reset_seen <= 1'b1;
        end
        if ($isunknown({J, K, Reset})) begin
            $error("jk_flip_flop: X/Z on J, K or Reset at rising Clk");
        end
        if ((reset_seen === 1'b1) && (Q_bar !== ~Q)) begin
            $error("jk_flip_flop: Q_bar is not the complement of Q");
        end
    end
`endif

endmodule

// File: tb/tb_jk_flip_flop.sv
// Bench for jk_flip_flop: directed timeline on a 1-bit instance, the 4-bit mixed-mode
// case, then randomized J/K/Reset with between-edge glitches against a per-bit model.
module tb_jk_flip_flop;

    localparam int unsigned W1 = 1;
    localparam int unsigned W4 = 4;
    localparam logic [W4-1:0] RV4 = 4'b1010;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [63:0] q1_m;
    logic [63:0] q4_m;

    jk_flip_flop_if #(.WIDTH(W1)) if1 ();
    jk_flip_flop_if #(.WIDTH(W4)) if4 ();

    jk_flip_flop #(.WIDTH(W1)) dut1 (
        .J     (if1.j),
        .K     (if1.k),
        .Reset (reset),
        .Clk   (clk),
        .Q     (if1.q),
        .Q_bar (if1.q_bar)
    );

    jk_flip_flop #(.WIDTH(W4), .RESET_VALUE(RV4)) dut4 (
        .J     (if4.j),
        .K     (if4.k),
        .Reset (reset),
        .Clk   (clk),
        .Q     (if4.q),
        .Q_bar (if4.q_bar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour: JK truth table applied bit by bit.
    function automatic logic [63:0] jk_next(input logic [63:0] q, input logic [63:0] j,
                                            input logic [63:0] k, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            case ({j[i], k[i]})
                2'b10:   r[i] = 1'b1;
                2'b01:   r[i] = 1'b0;
                2'b11:   r[i] = ~q[i];
                default: r[i] = q[i];
            endcase
        end
        return r;
    endfunction

    function automatic logic [63:0] mask(input int w);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < w; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Advance one rising edge, update both models from the settled inputs, compare #1 later.
    task automatic step();
        logic        r;
        logic [63:0] j1, k1, j4, k4;
        r  = reset;
        j1 = 64'(if1.j);
        k1 = 64'(if1.k);
        j4 = 64'(if4.j);
        k4 = 64'(if4.k);
        @(posedge clk);
        #1;
        q1_m = r ? 64'(1'b0) : jk_next(q1_m, j1, k1, W1);
        q4_m = r ? 64'(RV4)  : jk_next(q4_m, j4, k4, W4);
        check("w1_q",     64'(if1.q),     q1_m);
        check("w1_q_bar", 64'(if1.q_bar), ~q1_m & mask(W1));
        check("w4_q",     64'(if4.q),     q4_m);
        check("w4_q_bar", 64'(if4.q_bar), ~q4_m & mask(W4));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        q1_m   = '0;
        q4_m   = '0;
        reset  = 1'b1;
        if1.j  = '0;
        if1.k  = '0;
        if4.j  = '0;
        if4.k  = '0;

        // Reset at the 5 ns edge
        step();
        check("rst_q",     64'(if1.q),     64'd0);
        check("rst_q_bar", 64'(if1.q_bar), 64'd1);
        check("rst_q4",    64'(if4.q),     64'(RV4));

        // Set, idempotent across further edges; 4-bit mixed hold/set/clear/toggle
        reset = 1'b0;
        if1.j = 1'b1;
        if4.j = 4'b0011;
        if4.k = 4'b0101;
        step();
        check("set_q",     64'(if1.q),     64'd1);
        check("mix_q4",    64'(if4.q),     64'(4'b1011));
        check("mix_q4bar", 64'(if4.q_bar), 64'(4'b0100));
        if4.j = '0;
        if4.k = '0;
        step();
        step();
        check("set_idem", 64'(if1.q), 64'd1);

        // Clear
        if1.j = 1'b0;
        if1.k = 1'b1;
        step();
        check("clr_q", 64'(if1.q), 64'd0);

        // Held 11 divides the clock by two
        if1.j = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("tog_q", 64'(if1.q), 64'((i % 2) == 0));
        end

        // Reset beats toggle while Q=1
        reset = 1'b1;
        step();
        check("rst_wins", 64'(if1.q), 64'd0);

        // Set again, then a reset pulse and a K glitch entirely between edges
        reset = 1'b0;
        if1.k = 1'b0;
        step();
        check("reset_then_set", 64'(if1.q), 64'd1);
        if1.j = 1'b0;
        #2 reset = 1'b1;
        #2 check("mid_rst_q", 64'(if1.q), 64'd1);
        reset = 1'b0;
        if1.k = 1'b1;
        #2 if1.k = 1'b0;
        step();
        check("pulse_hold", 64'(if1.q), 64'd1);

        // Randomized J/K/Reset with glitches that are withdrawn before the edge
        for (int n = 0; n < 300; n++) begin
            if (($urandom % 3) == 0) begin
                reset = 1'($urandom);
                if1.j = W1'($urandom);
                if1.k = W1'($urandom);
                if4.j = W4'($urandom);
                if4.k = W4'($urandom);
                #2;
            end
            reset = (($urandom % 8) == 0);
            if1.j = W1'($urandom);
            if1.k = W1'($urandom);
            if4.j = W4'($urandom);
            if4.k = W4'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_flip_flop.md
JK_FLIP_FLOP -- requirements
Module: jk_flip_flop

Interface
REQ-001 Parameter: WIDTH, 1, number of independent JK bits; legal range 1..64.
REQ-002 Parameter: RESET_VALUE, {WIDTH{1'b0}}, value loaded into Q on reset.
REQ-003 Port: Clk  input  1  single clock; all state updates on rising edge only.
REQ-004 Port: Reset  input  1  synchronous, active-high reset.
REQ-005 Port: J  input  WIDTH  per-bit set request.
REQ-006 Port: K  input  WIDTH  per-bit clear request.
REQ-007 Port: Q  output  WIDTH  registered state.
REQ-008 Port: Q_bar  output  WIDTH  bitwise complement of Q.
REQ-009 Positional port order SHALL be J, K, Reset, Clk, Q, Q_bar so that unnamed instantiation binds correctly.
REQ-010 One clock; reset is synchronous and active-high; the ports are named Clk and Reset.

Function
REQ-011 Each bit i SHALL update on rising Clk per {J[i],K[i]}: 00 hold, 10 set Q[i]=1, 01 clear Q[i]=0, 11 toggle Q[i]=~Q[i].
REQ-012 Bits SHALL be fully independent; no bit's next state depends on another bit.
REQ-013 Latency SHALL be one edge: inputs sampled at edge n appear on Q immediately after edge n.
REQ-014 Q SHALL be a register output; Q_bar SHALL be driven combinationally as ~Q, never as a separate flop, so Q_bar == ~Q at all times after the first defined edge.
REQ-015 Input changes between rising edges SHALL have no effect on Q.
REQ-016 Repeated 11 on consecutive edges SHALL toggle on every edge (divide-by-2 of Clk).
REQ-017 No latches, no gated clocks, no combinational path from J/K/Reset to Q or Q_bar.

Reset
REQ-018 With Reset=1 at a rising edge, Q SHALL load RESET_VALUE regardless of J and K (reset has priority over 11 toggle).
REQ-019 Reset asserted between edges SHALL not change Q until the next rising edge.
REQ-020 On the first edge with Reset=0, normal JK behaviour SHALL apply to the values then on J/K.
REQ-021 Q SHALL have no initial value; before the first reset edge Q and Q_bar are unknown in simulation.

Configuration
REQ-022 Macro JKFF_SIM_CHECK_EN, when defined, SHALL compile in simulation-only checks: error message if J, K or Reset is X/Z at a rising Clk edge, and error if Q_bar != ~Q after any edge following reset.
REQ-023 Without JKFF_SIM_CHECK_EN the checks SHALL be absent and the synthesised logic identical in both builds.

Verification
REQ-024 Clk period 10 ns, first rising edge at 5 ns; Reset=1 for 0-10 ns, J=K=0 -> Q=0, Q_bar=1 after 5 ns edge.
REQ-025 J=1,K=0 applied at 12 ns -> Q=1 after 15 ns edge, still 1 after 25 and 35 ns edges (set is idempotent).
REQ-026 J=0,K=1 applied at 37 ns -> Q=0 after 45 ns edge.
REQ-027 J=1,K=1 applied at 47 ns -> Q=1 after 55 ns; holding 11 -> Q toggles 0,1,0 on following edges.
REQ-028 J=1,K=1 with Reset=1 at an edge while Q=1 -> Q=0 (reset wins); Reset pulse between edges only -> Q unchanged.
REQ-029 WIDTH=4, Q=4'b1010, J=4'b0011, K=4'b0101 at one edge -> Q=4'b1011, Q_bar=4'b0100.
